// File: rtl/htif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | htif_pkg                                                             |
// | Shared definitions for both ends of the 4-bit HTIF link: command     |
// | codes, the ACK byte, packet lengths in nibbles and length helpers.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package htif_pkg;

  typedef enum logic [2:0] {
    CMD_RDMEM = 3'd0,
    CMD_WRMEM = 3'd1,
    CMD_RDCR  = 3'd2,
    CMD_WRCR  = 3'd3,
    CMD_START = 3'd4,
    CMD_STOP  = 3'd5
  } htif_cmd_e;

  localparam logic [7:0] CMD_ACK = 8'h06;

  // Largest packets in each direction, in nibbles.
  localparam int unsigned TX_NIBS = 42;
  localparam int unsigned RX_NIBS = 34;

  localparam logic [5:0] TX_LEN_RDMEM = 6'd10;
  localparam logic [5:0] TX_LEN_WRMEM = 6'd42;
  localparam logic [5:0] TX_LEN_RDCR  = 6'd10;
  localparam logic [5:0] TX_LEN_WRCR  = 6'd18;
  localparam logic [5:0] TX_LEN_START = 6'd10;
  localparam logic [5:0] TX_LEN_STOP  = 6'd2;

  localparam logic [5:0] RX_LEN_RDMEM = 6'd34;
  localparam logic [5:0] RX_LEN_RDCR  = 6'd10;
  localparam logic [5:0] RX_LEN_ACK   = 6'd2;

  function automatic logic cmd_valid(input logic [2:0] cmd);
    return (cmd <= 3'd5);
  endfunction

  function automatic logic [5:0] tx_len(input logic [2:0] cmd);
    case (cmd)
      CMD_RDMEM: return TX_LEN_RDMEM;
      CMD_WRMEM: return TX_LEN_WRMEM;
      CMD_RDCR:  return TX_LEN_RDCR;
      CMD_WRCR:  return TX_LEN_WRCR;
      CMD_START: return TX_LEN_START;
      default:   return TX_LEN_STOP;
    endcase
  endfunction

  function automatic logic [5:0] rx_len(input logic [2:0] cmd);
    case (cmd)
      CMD_RDMEM: return RX_LEN_RDMEM;
      CMD_RDCR:  return RX_LEN_RDCR;
      default:   return RX_LEN_ACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/htif_link_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | htif_link_timeout                                                    |
// | Saturating idle-cycle counter. Counts every cycle unless cleared and  |
// | flags expiry once it reaches TIMEOUT_CYCLES; it never wraps.          |
// | Ports: clk, rst, clr_i (clear, dominant), expired_o.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module htif_link_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_BITS        = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [TO_BITS-1:0] C_LIMIT = TO_BITS'(TIMEOUT_CYCLES);
  localparam logic [TO_BITS-1:0] C_ONE   = TO_BITS'(1);

  logic [TO_BITS-1:0] cnt_q;

  assign expired_o = (cnt_q == C_LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (!expired_o) begin
      cnt_q <= cnt_q + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/htif_host_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | htif_host_initiator                                                  |
// | Host end of the 4-bit HTIF link. Serialises one command into a nibble |
// | packet (LSB nibble first), collects the response packet, checks the   |
// | ACK byte and returns read data.                                       |
// | Ports: req_* command handshake, resp_* completion handshake,          |
// |        link_out_* to chip in_*, link_in_* from chip out_*, busy.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module htif_host_initiator
  import htif_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_BITS        = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_val,
  output logic         req_rdy,
  input  logic [2:0]   req_cmd,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_data,
  output logic         resp_val,
  input  logic         resp_rdy,
  output logic [127:0] resp_data,
  output logic         resp_err,
  output logic         link_out_val,
  input  logic         link_out_rdy,
  output logic [3:0]   link_out_bits,
  input  logic         link_in_val,
  output logic         link_in_rdy,
  input  logic [3:0]   link_in_bits,
  output logic         busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RECV = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [2:0]             cmd_q, cmd_d;
  logic                   err_q, err_d;
  logic [TX_NIBS*4-1:0]   tx_q, tx_d;
  logic [RX_NIBS*4-1:0]   rx_q, rx_d;

  logic                   w_rx_phase;
  logic                   w_sent;
  logic                   w_to_clr;
  logic                   w_to_expired;

  assign w_rx_phase = (state_q == S_WAIT) || (state_q == S_RECV);
  // Only the first nibble waits for the chip; after that the packet must
  // stream without gaps, so later nibbles go out every cycle.
  assign w_sent     = (state_q == S_SEND) && ((cnt_q != 6'd0) || link_out_rdy);
  // Idle time is only measured while a response is expected; any received
  // nibble restarts the window.
  assign w_to_clr   = !w_rx_phase || link_in_val;

  htif_link_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_BITS        (TO_BITS)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_to_clr),
    .expired_o (w_to_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          tx_d  = {req_data, req_addr, 5'b0, req_cmd};
          rx_d  = '0;
          cmd_d = req_cmd;
          cnt_d = 6'd0;
          if (cmd_valid(req_cmd)) begin
            err_d   = 1'b0;
            state_d = S_SEND;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (w_sent) begin
          if (cnt_q == tx_len(cmd_q) - 6'd1) begin
            cnt_d   = 6'd0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_WAIT, S_RECV: begin
        if (link_in_val) begin
          rx_d[{cnt_q, 2'b00} +: 4] = link_in_bits;
          cnt_d   = cnt_q + 6'd1;
          state_d = (cnt_q + 6'd1 == rx_len(cmd_q)) ? S_DONE : S_RECV;
        end else if (w_to_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      cmd_q   <= 3'd0;
      err_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  // All outputs decode registered state only.
  assign req_rdy       = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign link_out_val  = (state_q == S_SEND);
  assign link_out_bits = (state_q == S_SEND) ? tx_q[{cnt_q, 2'b00} +: 4] : 4'h0;
  assign link_in_rdy   = w_rx_phase;
  assign resp_val      = (state_q == S_DONE);
  assign resp_err      = (state_q == S_DONE) && (err_q || (rx_q[7:0] != CMD_ACK));

  always_comb begin
    resp_data = '0;
    if (state_q == S_DONE) begin
      if (cmd_q == CMD_RDMEM) begin
        resp_data = rx_q[RX_NIBS*4-1:8];
      end else if (cmd_q == CMD_RDCR) begin
        resp_data = {96'd0, rx_q[39:8]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_htif_host_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_htif_host_initiator                                               |
// | Directed bench: a table of command/response vectors plus hand-written |
// | sequences for reset, bad command, mid-packet reset and timeout.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_htif_host_initiator;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;   // 0: default DUT, 1: short-timeout DUT
  logic         req_val = 1'b0;
  logic [2:0]   req_cmd = 3'd0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic         resp_rdy = 1'b0;
  logic         link_out_rdy = 1'b1;
  logic         link_in_val = 1'b0;
  logic [3:0]   link_in_bits = 4'h0;

  logic         req_rdy1, resp_val1, resp_err1, lov1, lir1, busy1;
  logic [127:0] resp_data1;
  logic [3:0]   lob1;
  logic         req_rdy2, resp_val2, resp_err2, lov2, lir2, busy2;
  logic [127:0] resp_data2;
  logic [3:0]   lob2;

  logic         w_req_rdy, w_resp_val, w_resp_err, w_lov, w_lir, w_busy;
  logic [127:0] w_resp_data;
  logic [3:0]   w_lob;

  assign w_req_rdy   = sel ? req_rdy2   : req_rdy1;
  assign w_resp_val  = sel ? resp_val2  : resp_val1;
  assign w_resp_err  = sel ? resp_err2  : resp_err1;
  assign w_resp_data = sel ? resp_data2 : resp_data1;
  assign w_lov       = sel ? lov2       : lov1;
  assign w_lob       = sel ? lob2       : lob1;
  assign w_lir       = sel ? lir2       : lir1;
  assign w_busy      = sel ? busy2      : busy1;

  always #5 clk = ~clk;

  htif_host_initiator dut (
    .clk (clk), .rst (rst),
    .req_val (req_val && !sel), .req_rdy (req_rdy1), .req_cmd (req_cmd),
    .req_addr (req_addr), .req_data (req_data),
    .resp_val (resp_val1), .resp_rdy (resp_rdy && !sel),
    .resp_data (resp_data1), .resp_err (resp_err1),
    .link_out_val (lov1), .link_out_rdy (link_out_rdy), .link_out_bits (lob1),
    .link_in_val (link_in_val), .link_in_rdy (lir1), .link_in_bits (link_in_bits),
    .busy (busy1)
  );

  htif_host_initiator #(.TIMEOUT_CYCLES(4), .TO_BITS(3)) dut_to (
    .clk (clk), .rst (rst),
    .req_val (req_val && sel), .req_rdy (req_rdy2), .req_cmd (req_cmd),
    .req_addr (req_addr), .req_data (req_data),
    .resp_val (resp_val2), .resp_rdy (resp_rdy && sel),
    .resp_data (resp_data2), .resp_err (resp_err2),
    .link_out_val (lov2), .link_out_rdy (link_out_rdy), .link_out_bits (lob2),
    .link_in_val (link_in_val), .link_in_rdy (lir2), .link_in_bits (link_in_bits),
    .busy (busy2)
  );

  typedef struct {
    string        name;
    logic [2:0]   cmd;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [7:0]   ack;
    logic [127:0] rdata;
    int           gap;
    bit           drop_rdy;
    int           exp_tx;
    int           rx_len;
    bit           chk_data;
    logic [127:0] exp_data;
    bit           exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [3:0] tx_nib [0:63];
  int ntx;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    logic [167:0] pkt;
    logic [135:0] rsp;
    bit           started;
    bit           nib_ok;
    int           sent;
    int           k;
    pkt = {v.data, v.addr, 5'b0, v.cmd};
    rsp = {v.rdata, v.ack};
    req_cmd  = v.cmd;
    req_addr = v.addr;
    req_data = v.data;
    req_val  = 1'b1;
    tick();
    req_val = 1'b0;
    chk({v.name, "_busy"}, w_busy, 1);
    // Collect the transmitted packet; a gap ends collection early.
    ntx = 0;
    started = 0;
    for (int c = 0; c < 200; c++) begin
      if (w_lov) begin
        if (ntx < 64) tx_nib[ntx] = w_lob;
        ntx++;
        started = 1;
      end else if (started) begin
        break;
      end
      link_out_rdy = !(v.drop_rdy && ntx >= 10 && ntx < 15);
      tick();
    end
    link_out_rdy = 1'b1;
    chk({v.name, "_tx_len"}, ntx, v.exp_tx);
    nib_ok = 1;
    for (int i = 0; i < ntx && i < 64; i++)
      if (tx_nib[i] !== pkt[i*4 +: 4]) nib_ok = 0;
    chk({v.name, "_tx_nibbles"}, nib_ok, 1);
    // Respond, with optional idle gaps before each nibble.
    sent = 0;
    for (int i = 0; i < v.rx_len; i++) begin
      repeat (v.gap) tick();
      if (!w_lir) break;
      link_in_val  = 1'b1;
      link_in_bits = rsp[i*4 +: 4];
      tick();
      link_in_val = 1'b0;
      sent++;
    end
    if (sent == v.rx_len) begin
      chk({v.name, "_resp_latency"}, w_resp_val, 1);
    end else begin
      k = 0;
      while (!w_resp_val && k < 20) begin
        tick();
        k++;
      end
      chk({v.name, "_resp_val"}, w_resp_val, 1);
    end
    chk({v.name, "_resp_err"}, w_resp_err, v.exp_err);
    if (v.chk_data) chk({v.name, "_resp_data"}, w_resp_data, v.exp_data);
    tick();
    chk({v.name, "_resp_hold"}, w_resp_val, 1);
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    chk({v.name, "_back_idle"}, {w_req_rdy, w_busy, w_resp_val}, 3'b100);
  endtask

  vec_t vecs [0:6];
  vec_t v_rdcr;
  vec_t v_to;
  logic [3:0] rdcr_exp [0:9];

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v_rdcr = '{"rdcr", 3'd2, 32'h0001_0000, 128'd0, 8'h06, {96'd0, 32'hDEADBEEF},
               0, 0, 10, 10, 1, {96'd0, 32'hDEADBEEF}, 0};
    vecs[0] = v_rdcr;
    vecs[1] = '{"wrmem", 3'd1, 32'h0000_0100, 128'h0123456789ABCDEF0123456789ABCDEF,
                8'h06, 128'd0, 0, 1, 42, 2, 1, 128'd0, 0};
    vecs[2] = '{"rdmem_gap", 3'd0, 32'h0000_2000, 128'd0, 8'h06,
                128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0, 5, 0, 10, 34, 1,
                128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0, 0};
    vecs[3] = '{"stop_nak", 3'd5, 32'h0000_0000, 128'd0, 8'h07, 128'd0,
                0, 0, 2, 2, 1, 128'd0, 1};
    vecs[4] = '{"wrcr", 3'd3, 32'h0002_0004, {96'd0, 32'h1234_5678}, 8'h06, 128'd0,
                0, 0, 18, 2, 1, 128'd0, 0};
    vecs[5] = '{"start", 3'd4, 32'h0003_0000, 128'd0, 8'h06, 128'd0,
                1, 0, 10, 2, 1, 128'd0, 0};
    vecs[6] = '{"rdcr_badack", 3'd2, 32'h0000_0010, 128'd0, 8'h16, {96'd0, 32'h5555_AAAA},
                0, 0, 10, 10, 0, 128'd0, 1};
    v_to    = '{"rdmem_timeout", 3'd0, 32'h0000_2000, 128'd0, 8'h06, 128'hFFFF,
                5, 0, 10, 34, 0, 128'd0, 1};
    rdcr_exp = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};

    repeat (3) tick();
    rst = 1'b0;
    // Reset state
    chk("rst_req_rdy_busy", {w_req_rdy, w_busy}, 2'b10);
    chk("rst_link", {w_lov, w_lir, w_lob}, 6'd0);
    chk("rst_resp", {w_resp_val, w_resp_err}, 2'b00);
    chk("rst_resp_data", w_resp_data, 128'd0);

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // Exact nibble sequence for rdcr at core 1
    do_txn(v_rdcr);
    for (int i = 0; i < 10; i++)
      chk($sformatf("rdcr_nib%0d", i), tx_nib[i], rdcr_exp[i]);

    // Short-timeout instance with the same 5-cycle gap must abort
    sel = 1'b1;
    tick();
    do_txn(v_to);
    sel = 1'b0;
    tick();

    // Undefined command: no link traffic, error completion
    begin
      bit seen_out;
      req_cmd = 3'd6;
      req_val = 1'b1;
      tick();
      req_val = 1'b0;
      seen_out = w_lov;
      if (!w_resp_val) begin
        tick();
        seen_out |= w_lov;
      end
      chk("badcmd_resp_val", w_resp_val, 1);
      chk("badcmd_resp_err", w_resp_err, 1);
      chk("badcmd_no_link", seen_out, 0);
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
      chk("badcmd_idle", w_req_rdy, 1);
    end

    // Reset in the middle of a wrmem packet
    begin
      int cnt;
      req_cmd  = 3'd1;
      req_addr = 32'h100;
      req_data = 128'h0123456789ABCDEF0123456789ABCDEF;
      req_val  = 1'b1;
      tick();
      req_val = 1'b0;
      cnt = 0;
      for (int c = 0; c < 60 && cnt < 20; c++) begin
        if (w_lov) cnt++;
        if (cnt < 20) tick();
      end
      chk("midrst_reached20", cnt, 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_link_out_val", w_lov, 0);
      chk("midrst_req_rdy", w_req_rdy, 1);
      do_txn(v_rdcr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
